// File: rtl/eif_pkg.sv
// eif_pkg: shared types, default constants and the neuron update arithmetic
// for the EIF layer scheduler.
//
// Contents:
//   sched_state_t  - sweep controller states (IDLE, SWEEP, DONE)
//   state_t/thr_t/cur_t - 8-bit membrane state, threshold and input current
//   upd_t          - result of one neuron update (spike flag, next state/thr)
//   *_DEF          - default threshold/adaptation constants
//   sat_add        - 9-bit saturating membrane accumulate
//   q8_scale       - Q8 threshold scaling (17-bit product, low 8 bits kept)
//   eif_update     - full per-neuron update including threshold adaptation
package eif_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } sched_state_t;

  typedef logic [7:0] state_t;
  typedef logic [7:0] thr_t;
  typedef logic [7:0] cur_t;

  typedef struct packed {
    logic   spike;
    state_t state;
    thr_t   thr;
  } upd_t;

  localparam int THRESH_INIT_DEF = 100;
  localparam int THRESH_MAX_DEF  = 220;
  localparam int THRESH_MIN_DEF  = 32;
  localparam int ADAPT_INC_DEF   = 295;
  localparam int ADAPT_DEC_DEF   = 250;

  // Membrane accumulate: the carry out of the 9-bit sum pins the result at 255.
  function automatic state_t sat_add(input state_t st, input cur_t cur);
    logic [8:0] sum;
    sum = {1'b0, st} + {1'b0, cur};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // Threshold scaling by a Q8 multiplier. The product is 17 bits; after the
  // shift only the low 8 bits survive, so results above 255 wrap.
  function automatic thr_t q8_scale(input thr_t thr, input logic [8:0] mult);
    logic [16:0] prod;
    prod = {9'b0, thr} * {8'b0, mult};
    return thr_t'(prod >> 8);
  endfunction

  // One neuron update on the stored values. Adaptation raises the threshold
  // after a spike (bounded by thr_max) and lowers it otherwise (bounded by
  // thr_min); the bounds gate whether the scaling happens at all.
  function automatic upd_t eif_update(input state_t     st,
                                      input thr_t       thr,
                                      input cur_t       cur,
                                      input logic       adapt,
                                      input thr_t       thr_max,
                                      input thr_t       thr_min,
                                      input logic [8:0] inc,
                                      input logic [8:0] dec);
    upd_t r;
    r.spike = (st >= thr);
    r.thr   = thr;
    if (r.spike) begin
      r.state = '0;
      if (adapt && (thr < thr_max)) r.thr = q8_scale(thr, inc);
    end else begin
      r.state = sat_add(st, cur);
      if (adapt && (thr > thr_min)) r.thr = q8_scale(thr, dec);
    end
    return r;
  endfunction

endpackage

// File: rtl/eif_layer_scheduler_if.sv
// eif_layer_scheduler_if: groups the host current-write bus and the spike
// event stream of the EIF layer scheduler.
//
// Signals:
//   cur_we/cur_addr/cur_data - current write strobe, neuron index, value
//   ev_valid/ev_ready/ev_addr - spike event handshake and neuron index
// Modports:
//   master - the scheduler side (consumes writes, produces events)
//   slave  - the environment side (host loader + spike router)
interface eif_layer_scheduler_if #(
  parameter int ADDR_W = 4
);
  import eif_pkg::*;

  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  cur_t              cur_data;
  logic              ev_valid;
  logic              ev_ready;
  logic [ADDR_W-1:0] ev_addr;

  modport master (
    input  cur_we, cur_addr, cur_data, ev_ready,
    output ev_valid, ev_addr
  );

  modport slave (
    output cur_we, cur_addr, cur_data, ev_ready,
    input  ev_valid, ev_addr
  );

endinterface

// File: rtl/eif_event_fifo.sv
// eif_event_fifo: small synchronous FIFO carrying spike addresses from the
// sweep datapath to the downstream router.
//
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   push        - enqueue request (never stalls the producer)
//   push_data   - address to enqueue
//   clear_ovf   - clears the sticky overflow flag
//   out_valid   - FIFO non-empty
//   out_ready   - consumer accepts the head entry
//   out_data    - head entry (held while out_valid && !out_ready)
//   overflow    - sticky: a push was dropped because the FIFO was full
// DEPTH must be a power of two, at least 2.
module eif_event_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              clear_ovf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              full;
  logic              pop;
  logic              push_ok;

  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok   = push && (!full || pop);

  // Storage and pointers; pointers wrap naturally because DEPTH is 2^PTR_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky drop flag; a clear wins over a simultaneous drop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end else if (push && !push_ok) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/eif_layer_scheduler.sv
// eif_layer_scheduler: time-multiplexed controller for a layer of
// exponential-integrate-and-fire neurons. One shared datapath sweeps every
// neuron once per timestep; spikes leave as neuron addresses via a FIFO.
//
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   step_start  - pulse that starts a sweep (accepted only when idle)
//   adaptive_en - enables threshold adaptation during the sweep
//   busy        - sweep in progress
//   step_done   - one-cycle pulse after the last neuron is updated
//   ev_overflow - sticky: an event was dropped on a full FIFO
//   bus         - eif_layer_scheduler_if.master (current writes, events)
//
// Build option: define EIF_SCHED_ADAPT_EN to compile in per-neuron threshold
// registers and adaptation. Without it every threshold is THRESH_INIT and
// adaptive_en has no effect.
module eif_layer_scheduler
  import eif_pkg::*;
#(
  parameter int N_NEURONS   = 16,
  parameter int ADDR_W      = 4,
  parameter int THRESH_INIT = THRESH_INIT_DEF,
  parameter int THRESH_MAX  = THRESH_MAX_DEF,
  parameter int THRESH_MIN  = THRESH_MIN_DEF,
  parameter int ADAPT_INC   = ADAPT_INC_DEF,
  parameter int ADAPT_DEC   = ADAPT_DEC_DEF,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  step_start,
  input  logic                  adaptive_en,
  output logic                  busy,
  output logic                  step_done,
  output logic                  ev_overflow,
  eif_layer_scheduler_if.master bus
);

  sched_state_t      fsm_q, fsm_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              start_ok;
  logic              upd_en;

  state_t            mem_state [N_NEURONS];
  cur_t              mem_cur   [N_NEURONS];

  logic              upd_spike;
  state_t            upd_state;

  logic              fifo_valid;
  logic [ADDR_W-1:0] fifo_data;

  // Sweep controller registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q <= IDLE;
      idx_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      idx_q <= idx_d;
    end
  end

  // Next-state logic: one neuron per SWEEP cycle, then a single DONE cycle.
  // step_start is only looked at in IDLE, which makes the minimum step
  // period N_NEURONS+2.
  always_comb begin
    fsm_d     = fsm_q;
    idx_d     = idx_q;
    busy      = 1'b0;
    step_done = 1'b0;
    start_ok  = 1'b0;
    upd_en    = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (step_start) begin
          fsm_d    = SWEEP;
          idx_d    = '0;
          start_ok = 1'b1;
        end
      end
      SWEEP: begin
        busy   = 1'b1;
        upd_en = 1'b1;
        if (idx_q == ADDR_W'(N_NEURONS - 1)) begin
          fsm_d = DONE;
          idx_d = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        step_done = 1'b1;
        fsm_d     = IDLE;
      end
      default: begin
        fsm_d = IDLE;
        idx_d = '0;
      end
    endcase
  end

`ifdef EIF_SCHED_ADAPT_EN
  thr_t mem_thr [N_NEURONS];
  upd_t upd;

  // Full update with adaptation, evaluated on the stored neuron values.
  always_comb begin
    upd = eif_update(mem_state[idx_q], mem_thr[idx_q], mem_cur[idx_q],
                     adaptive_en,
                     thr_t'(THRESH_MAX), thr_t'(THRESH_MIN),
                     9'(ADAPT_INC), 9'(ADAPT_DEC));
    upd_spike = upd.spike;
    upd_state = upd.state;
  end

  // Per-neuron thresholds, written back only by the neuron being swept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) mem_thr[i] <= thr_t'(THRESH_INIT);
    end else if (upd_en) begin
      mem_thr[idx_q] <= upd.thr;
    end
  end
`else
  logic unused_adaptive_en;
  assign unused_adaptive_en = adaptive_en;

  // Fixed threshold: only the compare and the saturating accumulate remain.
  always_comb begin
    upd_spike = (mem_state[idx_q] >= thr_t'(THRESH_INIT));
    upd_state = upd_spike ? state_t'(0) : sat_add(mem_state[idx_q], mem_cur[idx_q]);
  end
`endif

  // Membrane state write-back for the neuron currently being swept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) mem_state[i] <= '0;
    end else if (upd_en) begin
      mem_state[idx_q] <= upd_state;
    end
  end

  // Host current writes land in any state. A write to the neuron under
  // update this cycle is seen only from the next sweep, because the update
  // reads the pre-edge value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) mem_cur[i] <= '0;
    end else if (bus.cur_we) begin
      mem_cur[bus.cur_addr] <= bus.cur_data;
    end
  end

  eif_event_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (upd_en && upd_spike),
    .push_data (idx_q),
    .clear_ovf (start_ok),
    .out_valid (fifo_valid),
    .out_ready (bus.ev_ready),
    .out_data  (fifo_data),
    .overflow  (ev_overflow)
  );

  assign bus.ev_valid = fifo_valid;
  assign bus.ev_addr  = fifo_data;

endmodule

// File: tb/tb_eif_layer_scheduler.sv
// tb_eif_layer_scheduler: self-checking bench for eif_layer_scheduler.
// A cycle-level reference model (plain arrays and counters) predicts the
// accepted spike events into a scoreboard queue; a monitor compares the DUT
// outputs each cycle and pops the scoreboard on every event handshake.
// Directed scenarios add fixed expectations on the observed event stream.
module tb_eif_layer_scheduler;

  localparam int N      = 16;
  localparam int AW     = 4;
  localparam int DEPTH  = 4;
  localparam int T_INIT = 100;
  localparam int T_MAX  = 220;
  localparam int T_MIN  = 32;
  localparam int A_INC  = 295;
  localparam int A_DEC  = 250;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic step_start = 1'b0;
  logic adaptive_en = 1'b0;
  logic busy, step_done, ev_overflow;

  eif_layer_scheduler_if #(.ADDR_W(AW)) bus ();

  eif_layer_scheduler #(
    .N_NEURONS(N), .ADDR_W(AW), .THRESH_INIT(T_INIT), .THRESH_MAX(T_MAX),
    .THRESH_MIN(T_MIN), .ADAPT_INC(A_INC), .ADAPT_DEC(A_DEC), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .step_start(step_start), .adaptive_en(adaptive_en),
    .busy(busy), .step_done(step_done), .ev_overflow(ev_overflow), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_compared = 0;
  int n_failed = 0;
  int cyc = 0;
  int start_cyc = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int obs_q[$];
  int exp_q[$];

  int m_state[N];
  int m_thr[N];
  int m_cur[N];
  int m_idx = -1;
  int m_occ = 0;
  bit m_done = 0;
  bit m_ovf = 0;
  bit model_live = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference model: advances on every rising edge from the inputs of the
  // cycle just ending.
  task automatic modelStep();
    bit pop;
    bit adapt;
    int i;
    int sum;
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        m_state[k] = 0;
        m_thr[k] = T_INIT;
        m_cur[k] = 0;
      end
      exp_q.delete();
      m_idx = -1;
      m_occ = 0;
      m_done = 0;
      m_ovf = 0;
      model_live = 1;
      return;
    end
    adapt = 0;
`ifdef EIF_SCHED_ADAPT_EN
    adapt = adaptive_en;
`endif
    pop = (m_occ != 0) && bus.ev_ready;
    if (m_idx >= 0) begin
      i = m_idx;
      if (m_state[i] >= m_thr[i]) begin
        m_state[i] = 0;
        if (adapt && m_thr[i] < T_MAX) m_thr[i] = ((m_thr[i] * A_INC) >> 8) & 255;
        if (m_occ - int'(pop) < DEPTH) begin
          exp_q.push_back(i);
          m_occ++;
        end else begin
          m_ovf = 1;
        end
      end else begin
        sum = m_state[i] + m_cur[i];
        m_state[i] = (sum > 255) ? 255 : sum;
        if (adapt && m_thr[i] > T_MIN) m_thr[i] = ((m_thr[i] * A_DEC) >> 8) & 255;
      end
      if (i == N - 1) begin
        m_idx = -1;
        m_done = 1;
      end else begin
        m_idx = i + 1;
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (step_start) begin
      m_idx = 0;
      m_ovf = 0;
    end
    if (bus.cur_we) m_cur[bus.cur_addr] = int'(bus.cur_data);
    if (pop) m_occ--;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    modelStep();
  end

  // Monitor: compares outputs mid-cycle and consumes the scoreboard on handshakes.
  initial forever begin
    @(negedge clk);
    if (busy) busy_cnt++;
    if (step_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (model_live) begin
      checkOutput("busy", int'(busy), int'(m_idx >= 0));
      checkOutput("step_done", int'(step_done), int'(m_done));
      checkOutput("ev_valid", int'(bus.ev_valid), int'(m_occ != 0));
      checkOutput("ev_overflow", int'(ev_overflow), int'(m_ovf));
      if (bus.ev_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("ev_unexpected", 1, 0);
        end else begin
          checkOutput("ev_addr", int'(bus.ev_addr), exp_q[0]);
          if (bus.ev_ready) void'(exp_q.pop_front());
        end
      end
    end
    if (bus.ev_valid && bus.ev_ready) obs_q.push_back(int'(bus.ev_addr));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    step_start = 1'b0;
    bus.cur_we = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic writeCur(input int a, input int d);
    bus.cur_we = 1'b1;
    bus.cur_addr = AW'(a);
    bus.cur_data = 8'(d);
    tick(1);
    bus.cur_we = 1'b0;
  endtask

  task automatic startStep();
    step_start = 1'b1;
    start_cyc = cyc;
    tick(1);
    step_start = 1'b0;
  endtask

  task automatic waitDone();
    bit found;
    found = 0;
    for (int k = 0; k < N + 8 && !found; k++) begin
      @(negedge clk);
      if (step_done) found = 1;
    end
    if (!found) checkOutput("step_timeout", 0, 1);
    tick(1);
  endtask

  task automatic runStep();
    startStep();
    waitDone();
    tick(DEPTH + 2);
  endtask

  // Randomized traffic: ready back-pressure, step pulses (ignored while
  // busy), current writes at any time including mid-sweep.
  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      bus.ev_ready = ($urandom_range(0, 3) != 0);
      step_start = ($urandom_range(0, 9) == 0);
      bus.cur_we = ($urandom_range(0, 4) == 0);
      bus.cur_addr = AW'($urandom_range(0, N - 1));
      bus.cur_data = 8'($urandom_range(0, 90));
      if (!busy && $urandom_range(0, 3) == 0) adaptive_en = 1'($urandom_range(0, 1));
      tick(1);
    end
    step_start = 1'b0;
    bus.cur_we = 1'b0;
    adaptive_en = 1'b0;
  endtask

  initial begin
    bus.cur_we = 1'b0;
    bus.cur_addr = '0;
    bus.cur_data = '0;
    bus.ev_ready = 1'b1;
    tick(3);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_step_done", int'(step_done), 0);
    checkOutput("rst_ev_valid", int'(bus.ev_valid), 0);
    checkOutput("rst_ev_addr", int'(bus.ev_addr), 0);
    checkOutput("rst_ev_overflow", int'(ev_overflow), 0);
    rst_n = 1'b1;
    tick(1);

    $display("[TB] scenario: fixed threshold, neuron 3 current 60");
    doReset();
    writeCur(3, 60);
    obs_q.delete();
    runStep();
    checkOutput("t1_step1_events", obs_q.size(), 0);
    runStep();
    checkOutput("t1_step2_events", obs_q.size(), 0);
    runStep();
    checkOutput("t1_step3_events", obs_q.size(), 1);
    if (obs_q.size() > 0) checkOutput("t1_step3_addr", obs_q[0], 3);

`ifdef EIF_SCHED_ADAPT_EN
    $display("[TB] scenario: adaptation, neuron 5 current 200");
    doReset();
    adaptive_en = 1'b1;
    writeCur(5, 200);
    obs_q.delete();
    runStep();
    checkOutput("t2_step1_events", obs_q.size(), 0);
    runStep();
    checkOutput("t2_step2_events", obs_q.size(), 1);
    runStep();
    checkOutput("t2_step3_events", obs_q.size(), 1);
    runStep();
    checkOutput("t2_step4_events", obs_q.size(), 2);
    if (obs_q.size() > 1) checkOutput("t2_step4_addr", obs_q[1], 5);
    adaptive_en = 1'b0;
`endif

    $display("[TB] scenario: all neurons spike into a stalled FIFO");
    doReset();
    bus.ev_ready = 1'b0;
    for (int a = 0; a < N; a++) writeCur(a, 255);
    runStep();
    runStep();
    checkOutput("t3_ev_valid", int'(bus.ev_valid), 1);
    checkOutput("t3_ev_addr", int'(bus.ev_addr), 0);
    checkOutput("t3_overflow_set", int'(ev_overflow), 1);
    startStep();
    checkOutput("t3_overflow_clr", int'(ev_overflow), 0);
    waitDone();
    obs_q.delete();
    bus.ev_ready = 1'b1;
    tick(DEPTH + 4);
    checkOutput("t3_drain_count", obs_q.size(), DEPTH);
    for (int k = 0; k < DEPTH && k < obs_q.size(); k++)
      checkOutput("t3_drain_addr", obs_q[k], k);

    $display("[TB] scenario: second step_start during a sweep");
    doReset();
    busy_cnt = 0;
    done_cnt = 0;
    startStep();
    tick(4);
    step_start = 1'b1;
    tick(1);
    step_start = 1'b0;
    tick(20);
    checkOutput("t4_busy_cycles", busy_cnt, N);
    checkOutput("t4_done_pulses", done_cnt, 1);
    checkOutput("t4_done_latency", done_cyc - start_cyc, N + 1);

    $display("[TB] scenario: current write while neuron 7 is updated");
    doReset();
    writeCur(7, 60);
    obs_q.delete();
    step_start = 1'b1;
    tick(1);
    step_start = 1'b0;
    tick(7);
    bus.cur_we = 1'b1;
    bus.cur_addr = AW'(7);
    bus.cur_data = 8'd100;
    tick(1);
    bus.cur_we = 1'b0;
    waitDone();
    tick(DEPTH + 2);
    checkOutput("t5_sweep1_events", obs_q.size(), 0);
    runStep();
    checkOutput("t5_sweep2_events", obs_q.size(), 0);
    runStep();
    checkOutput("t5_sweep3_events", obs_q.size(), 1);
    if (obs_q.size() > 0) checkOutput("t5_sweep3_addr", obs_q[0], 7);

    $display("[TB] scenario: reset in the middle of a sweep");
    doReset();
    writeCur(2, 255);
    writeCur(10, 255);
    runStep();
    step_start = 1'b1;
    tick(1);
    step_start = 1'b0;
    tick(7);
    rst_n = 1'b0;
    tick(1);
    checkOutput("t6_busy", int'(busy), 0);
    checkOutput("t6_ev_valid", int'(bus.ev_valid), 0);
    checkOutput("t6_step_done", int'(step_done), 0);
    rst_n = 1'b1;
    done_cnt = 0;
    tick(20);
    checkOutput("t6_no_done", done_cnt, 0);
    obs_q.delete();
    runStep();
    checkOutput("t6_no_events", obs_q.size(), 0);

    $display("[TB] scenario: randomized traffic");
    doReset();
    for (int a = 0; a < N; a++) writeCur(a, int'($urandom_range(0, 120)));
    applyStimulus(900);
    bus.ev_ready = 1'b1;
    tick(N + 2 * DEPTH + 8);
    checkOutput("rand_scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule

// File: doc/eif_layer_scheduler.md
# eif_layer_scheduler

Time-multiplexed controller for a layer of exponential-integrate-and-fire neurons. It stores per-neuron membrane state, threshold and input current, and sweeps one shared update datapath across all neurons once per timestep. Spike events are emitted as neuron addresses through a small FIFO with a valid/ready handshake. The block sits between the host-side current loader and the downstream spike router.

## Interface
- N_NEURONS, 16: neurons in the layer (power of two, 2–256)
- ADDR_W, 4: log2(N_NEURONS)
- THRESH_INIT, 100: reset threshold
- THRESH_MAX, 220: increase allowed only while threshold < this
- THRESH_MIN, 32: decrease allowed only while threshold > this
- ADAPT_INC, 295: increment multiplier (Q8)
- ADAPT_DEC, 250: decrement multiplier (Q8)
- FIFO_DEPTH, 4: event FIFO entries (power of two)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low; clock clk
- step_start  in  1  one-cycle pulse that starts a timestep sweep
- adaptive_en  in  1  enables threshold adaptation for the sweep
- cur_we  in  1  current write strobe
- cur_addr  in  ADDR_W  neuron index for the current write
- cur_data  in  8  input current
- busy  out  1  sweep in progress
- step_done  out  1  one-cycle pulse at sweep end
- ev_valid  out  1  event available
- ev_ready  in  1  downstream accepts the event
- ev_addr  out  ADDR_W  spiking neuron index
- ev_overflow  out  1  sticky flag: an event was dropped

## Operation
- FSM states: IDLE, SWEEP, DONE.
  - IDLE → SWEEP on step_start.
  - SWEEP visits index 0..N_NEURONS-1 at one neuron per cycle, then goes to DONE.
  - DONE lasts one cycle, asserts step_done, then returns to IDLE.
- step_start is ignored outside IDLE.
- Per-neuron update, evaluated on the stored values:
  - spike = state ≥ thr.
  - On spike: state ← 0. If adaptive_en and thr < THRESH_MAX, thr ← (thr·ADAPT_INC)>>8.
  - On no spike: state ← min(state+cur, 255), computed as a 9-bit sum that saturates. If adaptive_en and thr > THRESH_MIN, thr ← (thr·ADAPT_DEC)>>8.
  - Threshold products are 17 bits wide; the result keeps the low 8 bits after the shift.
- Currents persist until they are rewritten.
- cur_we is accepted in any state. If it targets the neuron being updated in the same cycle, the update uses the old current; the write still lands.
- Spike events:
  - Each spike pushes its index into the FIFO. The sweep never stalls.
  - If the FIFO is full, the event is dropped and ev_overflow is set.
  - ev_overflow clears on an accepted step_start.
  - A pop occurs when ev_valid && ev_ready.
  - When full, a push and a pop in the same cycle both succeed.
- Reset values:
  - state = 0 for all neurons; thr = THRESH_INIT; currents = 0.
  - FIFO empty.
  - busy = 0, step_done = 0, ev_valid = 0, ev_addr = 0, ev_overflow = 0.
  - FSM in IDLE.
- Reset mid-sweep aborts the sweep immediately. step_done is not pulsed.

## Timing
- step_start sampled high in cycle t:
  - busy is high in cycles t+1..t+N_NEURONS.
  - Neuron i is updated at the clock edge ending cycle t+1+i.
  - step_done is high in cycle t+1+N_NEURONS.
- Event from neuron i: ev_valid is high from cycle t+2+i at the earliest, if the FIFO was empty.
- FIFO output is registered. ev_addr and ev_valid hold stable while ev_valid && !ev_ready.
- Minimum step period is N_NEURONS+2 cycles.

## Configuration
- EIF_SCHED_ADAPT_EN
  - Defined: per-neuron threshold registers and the adaptation arithmetic are compiled in.
  - Undefined: thr is the constant THRESH_INIT for every neuron, there are no threshold registers or multipliers, and adaptive_en is ignored (the port is kept).

## Structure
- Package eif_pkg holds:
  - the FSM state enum;
  - the 8-bit state/threshold/current typedefs;
  - the default THRESH_*/ADAPT_* constants;
  - the update function (saturating add and Q8 scale).
- One sub-module: eif_event_fifo (sync FIFO, push/full/overflow, valid/ready pop side).

## Test plan
- Adaptation off, neuron 3 current 60, others 0:
  - step 1 → state 60; step 2 → 120, no event; step 3 → event ev_addr=3, state reset to 0.
- Adaptation on, neuron 5 current 200:
  - step 1: no spike, thr → 97.
  - step 2: event 5, thr → 111.
  - step 3: no spike, thr → 108.
  - step 4: event 5.
- All 16 currents 255, ev_ready=0, FIFO_DEPTH 4:
  - step 2 spikes all 16 neurons.
  - FIFO holds addr 0,1,2,3; ev_overflow=1.
  - Next step_start clears ev_overflow.
- step_start at t, repeated at t+5:
  - busy for 16 cycles; exactly one step_done, at t+17.
- cur_we to neuron 7 in the cycle neuron 7 is updated:
  - that sweep uses the old current; the next sweep uses the new one.
- rst_n low at neuron 7 mid-sweep:
  - busy=0, ev_valid=0, no step_done.
  - Next sweep from step_start produces no events (all states and currents 0).
